line_engine_scheduler: RTL and testbench
========================================

Name: line_engine_scheduler

Overview:
Sequences one line-KCPE conv2d engine over a full layer pass. It repeats weight load, activation-line stream and psum drain for every (kernel group, channel group) pair. It gates the engine enable, forwards data requests and tags partial sums so the downstream accumulator knows when to clear and when to write back. It sits between the layer control registers and line_kcpe_conv2d_engine.

Parameters:
CNT_WIDTH, 16, width of line-length and group counters
REG_WIDTH, 32, width of the engine configuration/control word
NUM_KCPE, 3, kernel-channel PEs per engine (positions per weight set)
WEIGHT_BEATS, 3, i_weight_val beats needed per weight load
DRAIN_TIMEOUT, 256, maximum idle cycles in DRAIN before error

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_start  in  1  one-cycle pulse that starts a layer pass
i_cfg_line_width  in  CNT_WIDTH  activation pixels per line
i_cfg_num_chgrp  in  CNT_WIDTH  channel groups (channels/3)
i_cfg_num_kngrp  in  CNT_WIDTH  kernel groups (kernels/4)
o_busy  out  1  high from accepted start until DONE exits
o_done  out  1  one-cycle pulse when the pass completes
o_err  out  1  one-cycle pulse on bad config or drain timeout
o_weight_req  out  1  requests weight beats from weight memory
i_weight_val  in  1  weight beat valid
i_engine_data_req  in  1  engine's o_data_req
o_data_req  out  1  request to activation memory
i_data_val  in  1  activation beat valid
i_psum_val  in  1  engine o_psum_kn0_val
o_conf_ctrl  out  REG_WIDTH  engine i_conf_ctrl; bit0 = enable, other bits 0
o_psum_first  out  1  current psums belong to channel group 0
o_psum_last  out  1  current psums belong to the last channel group
o_chgrp_idx  out  CNT_WIDTH  current channel group
o_kngrp_idx  out  CNT_WIDTH  current kernel group

Behaviour:
- Reset (rst=0, async): state IDLE. All counters 0. Every output 0.
- All outputs are registered except o_data_req = i_engine_data_req & (state==STREAM) & (data_cnt < line_width).
- IDLE: on i_start, latch the three cfg inputs. If line_width < NUM_KCPE or either group count is 0: pulse o_err, stay IDLE. Otherwise go to LOAD_W and set o_busy.
- LOAD_W: o_weight_req=1. Count i_weight_val. On the WEIGHT_BEATS-th beat, drop o_weight_req the next cycle and go to STREAM. Extra weight beats in other states are ignored.
- STREAM: o_conf_ctrl[0]=1. Count i_data_val beats; data_cnt saturates at line_width. When data_cnt reaches line_width, go to DRAIN. Beats with data_cnt==line_width are dropped.
- DRAIN: o_conf_ctrl[0] stays 1. Count i_psum_val until it reaches expected = line_width - NUM_KCPE + 1. A psum_val in the same cycle as the state entry is counted.
  - Timeout counter resets on each psum_val. If it reaches DRAIN_TIMEOUT: pulse o_err, clear o_conf_ctrl, go IDLE, drop o_busy.
- NEXT (1 cycle): o_conf_ctrl[0]=0; clear data/psum counters.
  - Increment chgrp_idx; on wrap to 0, increment kngrp_idx.
  - If both wrap, go to DONE; else go to LOAD_W.
- DONE (1 cycle): o_done=1, o_busy=0 the following cycle, return to IDLE.
- o_psum_first = busy & (chgrp_idx==0). o_psum_last = busy & (chgrp_idx==num_chgrp-1). Both are stable across LOAD_W..DRAIN of a pass.
- i_start while busy is ignored; cfg inputs are not resampled mid-pass.
- Async reset mid-pass returns to IDLE immediately with all outputs 0; no o_done or o_err.
- Counters compare on equality; no modular wrap inside STREAM or DRAIN.

Decomposition:
- Shared package: state encoding (IDLE, LOAD_W, STREAM, DRAIN, NEXT, DONE), CONF_CTRL_EN_BIT=0, default CNT_WIDTH/REG_WIDTH.
- One sub-module: group_loop_counter, a nested chgrp/kngrp counter with inc input and wrap/last outputs, reusable by later multi-engine schedulers.

Test Plan:
- line_width=8, chgrp=1, kngrp=1, 3 weight beats, 8 data beats, 6 psum_val -> o_done one cycle after NEXT. Exactly 1 LOAD_W. o_psum_first and o_psum_last both 1 throughout.
- line_width=5, chgrp=2, kngrp=2 -> 4 LOAD_W phases. (chgrp,kngrp) order is (0,0),(1,0),(0,1),(1,1). Each pass has 3 psums, 12 total, then o_done.
- Bad config: line_width=2 or kngrp=0 with i_start -> o_err for one cycle; o_busy stays 0; o_weight_req stays 0.
- Drain stall: stop psum_val after 2 of 6 -> o_err exactly DRAIN_TIMEOUT cycles after the last psum. State IDLE; o_conf_ctrl=0.
- Backpressure: toggle i_engine_data_req each cycle and send 10 data_val for line_width=8 -> o_data_req follows the request only while data_cnt<8. data_cnt stops at 8; the extra 2 beats are dropped.
- Assert rst low during STREAM and send i_start during busy -> all outputs 0 immediately on reset. The ignored i_start does not restart the pass or change the indices.

Source files
------------

// File: rtl/line_engine_scheduler_pkg.sv
// rtl/line_engine_scheduler_pkg.sv - shared state encoding and defaults for the line engine scheduler
// Purpose: state enum, control-word bit positions and default widths used by
//          line_engine_scheduler and its group counter.
// Ports:   none (package).
package line_engine_scheduler_pkg;

  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_REG_WIDTH    = 32;
  localparam int CONF_CTRL_EN_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } sched_state_e;

endpackage

// File: rtl/line_engine_scheduler_group_loop_counter.sv
// rtl/line_engine_scheduler_group_loop_counter.sv - nested channel-group / kernel-group loop counter
// Purpose: walks (chgrp, kngrp) with chgrp as the inner loop. One step per i_inc.
// Ports:   clk, rst (async active-low)
//          i_clr        return both indices to 0
//          i_inc        advance by one group pair
//          i_num_chgrp  inner loop length, i_num_kngrp outer loop length
//          o_chgrp_idx / o_kngrp_idx  current indices
//          o_chgrp_last inner index is at its final value
//          o_wrap       this increment wraps both loops back to (0,0)
module group_loop_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_inc,
  input  logic [CNT_WIDTH-1:0] i_num_chgrp,
  input  logic [CNT_WIDTH-1:0] i_num_kngrp,
  output logic [CNT_WIDTH-1:0] o_chgrp_idx,
  output logic [CNT_WIDTH-1:0] o_kngrp_idx,
  output logic                 o_chgrp_last,
  output logic                 o_wrap
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [CNT_WIDTH-1:0] chgrp_q, chgrp_d;
  logic [CNT_WIDTH-1:0] kngrp_q, kngrp_d;
  logic                 kngrp_last;

  assign o_chgrp_last = (chgrp_q == i_num_chgrp - CNT_ONE);
  assign kngrp_last   = (kngrp_q == i_num_kngrp - CNT_ONE);
  assign o_wrap       = i_inc & o_chgrp_last & kngrp_last;
  assign o_chgrp_idx  = chgrp_q;
  assign o_kngrp_idx  = kngrp_q;

  always_comb begin
    chgrp_d = chgrp_q;
    kngrp_d = kngrp_q;
    if (i_clr) begin
      chgrp_d = '0;
      kngrp_d = '0;
    end else if (i_inc) begin
      if (o_chgrp_last) begin
        chgrp_d = '0;
        kngrp_d = kngrp_last ? '0 : kngrp_q + CNT_ONE;
      end else begin
        chgrp_d = chgrp_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chgrp_q <= '0;
      kngrp_q <= '0;
    end else begin
      chgrp_q <= chgrp_d;
      kngrp_q <= kngrp_d;
    end
  end

endmodule

// File: rtl/line_engine_scheduler.sv
// rtl/line_engine_scheduler.sv - sequences one line conv2d engine over a full layer pass
// Purpose: per (kernel group, channel group) pair runs weight load, line stream
//          and psum drain, gating the engine enable and tagging psums.
// Ports:   clk, rst (async active-low)
//          i_start, i_cfg_line_width/num_chgrp/num_kngrp   layer control
//          o_busy, o_done, o_err                           status
//          o_weight_req / i_weight_val                     weight load handshake
//          i_engine_data_req, o_data_req, i_data_val       activation stream
//          i_psum_val                                      engine psum strobe
//          o_conf_ctrl                                     engine control word (bit0 enable)
//          o_psum_first/last, o_chgrp_idx, o_kngrp_idx     psum tagging
module line_engine_scheduler
  import line_engine_scheduler_pkg::*;
#(
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int REG_WIDTH     = DEF_REG_WIDTH,
  parameter int NUM_KCPE      = 3,
  parameter int WEIGHT_BEATS  = 3,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_cfg_line_width,
  input  logic [CNT_WIDTH-1:0] i_cfg_num_chgrp,
  input  logic [CNT_WIDTH-1:0] i_cfg_num_kngrp,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_weight_req,
  input  logic                 i_weight_val,
  input  logic                 i_engine_data_req,
  output logic                 o_data_req,
  input  logic                 i_data_val,
  input  logic                 i_psum_val,
  output logic [REG_WIDTH-1:0] o_conf_ctrl,
  output logic                 o_psum_first,
  output logic                 o_psum_last,
  output logic [CNT_WIDTH-1:0] o_chgrp_idx,
  output logic [CNT_WIDTH-1:0] o_kngrp_idx
);

  localparam int WB_W = $clog2(WEIGHT_BEATS + 1);
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] KCPE    = CNT_WIDTH'(NUM_KCPE);

  sched_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] lw_q, lw_d, nc_q, nc_d, nk_q, nk_d;
  logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d, psum_cnt_q, psum_cnt_d;
  logic [WB_W-1:0]      wcnt_q, wcnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 wreq_q, wreq_d, en_q, en_d;
  logic                 grp_clr, grp_inc, grp_wrap, chgrp_last;
  logic [CNT_WIDTH-1:0] psum_expect;

  // A line of W pixels through K positions yields W-K+1 valid outputs.
  assign psum_expect = lw_q - KCPE + CNT_ONE;

  group_loop_counter #(.CNT_WIDTH(CNT_WIDTH)) u_grp (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (grp_clr),
    .i_inc        (grp_inc),
    .i_num_chgrp  (nc_q),
    .i_num_kngrp  (nk_q),
    .o_chgrp_idx  (o_chgrp_idx),
    .o_kngrp_idx  (o_kngrp_idx),
    .o_chgrp_last (chgrp_last),
    .o_wrap       (grp_wrap)
  );

  always_comb begin
    state_d    = state_q;
    lw_d       = lw_q;
    nc_d       = nc_q;
    nk_d       = nk_q;
    data_cnt_d = data_cnt_q;
    psum_cnt_d = psum_cnt_q;
    wcnt_d     = wcnt_q;
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
    grp_clr    = 1'b0;
    grp_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          lw_d = i_cfg_line_width;
          nc_d = i_cfg_num_chgrp;
          nk_d = i_cfg_num_kngrp;
          if (i_cfg_line_width < KCPE || i_cfg_num_chgrp == '0 || i_cfg_num_kngrp == '0) begin
            err_d = 1'b1;
          end else begin
            // Indices may be mid-loop after an aborted pass, so always restart at (0,0).
            state_d    = ST_LOAD_W;
            grp_clr    = 1'b1;
            data_cnt_d = '0;
            psum_cnt_d = '0;
            wcnt_d     = '0;
            to_cnt_d   = '0;
          end
        end
      end
      ST_LOAD_W: begin
        if (i_weight_val) begin
          if (wcnt_q == WB_W'(WEIGHT_BEATS - 1)) begin
            wcnt_d  = '0;
            state_d = ST_STREAM;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (i_data_val && data_cnt_q != lw_q) begin
          data_cnt_d = data_cnt_q + CNT_ONE;
          if (data_cnt_q + CNT_ONE == lw_q) begin
            state_d  = ST_DRAIN;
            to_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (i_psum_val) begin
          psum_cnt_d = psum_cnt_q + CNT_ONE;
          to_cnt_d   = '0;
          if (psum_cnt_q + CNT_ONE == psum_expect) state_d = ST_NEXT;
        end else if (to_cnt_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_NEXT: begin
        data_cnt_d = '0;
        psum_cnt_d = '0;
        to_cnt_d   = '0;
        grp_inc    = 1'b1;
        state_d    = grp_wrap ? ST_DONE : ST_LOAD_W;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered images of the state being entered.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    wreq_d = (state_d == ST_LOAD_W);
    en_d   = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lw_q       <= '0;
      nc_q       <= '0;
      nk_q       <= '0;
      data_cnt_q <= '0;
      psum_cnt_q <= '0;
      wcnt_q     <= '0;
      to_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wreq_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lw_q       <= lw_d;
      nc_q       <= nc_d;
      nk_q       <= nk_d;
      data_cnt_q <= data_cnt_d;
      psum_cnt_q <= psum_cnt_d;
      wcnt_q     <= wcnt_d;
      to_cnt_q   <= to_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wreq_q     <= wreq_d;
      en_q       <= en_d;
    end
  end

  always_comb begin
    o_conf_ctrl                   = '0;
    o_conf_ctrl[CONF_CTRL_EN_BIT] = en_q;
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_weight_req = wreq_q;
  assign o_data_req   = i_engine_data_req & (state_q == ST_STREAM) & (data_cnt_q < lw_q);
  assign o_psum_first = busy_q & (o_chgrp_idx == '0);
  assign o_psum_last  = busy_q & chgrp_last;

endmodule

// File: tb/tb_line_engine_scheduler.sv
// tb/tb_line_engine_scheduler.sv - scoreboard bench for line_engine_scheduler
module tb_line_engine_scheduler;

  localparam int CW = 16;
  localparam int RW = 32;
  localparam int NK = 3;
  localparam int WB = 3;
  localparam int TO = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_weight_val, i_engine_data_req, i_data_val, i_psum_val;
  logic [CW-1:0] i_cfg_line_width, i_cfg_num_chgrp, i_cfg_num_kngrp;
  logic          o_busy, o_done, o_err, o_weight_req, o_data_req, o_psum_first, o_psum_last;
  logic [RW-1:0] o_conf_ctrl;
  logic [CW-1:0] o_chgrp_idx, o_kngrp_idx;

  always #5 clk = ~clk;

  line_engine_scheduler #(
    .CNT_WIDTH(CW), .REG_WIDTH(RW), .NUM_KCPE(NK), .WEIGHT_BEATS(WB), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_cfg_line_width  (i_cfg_line_width),
    .i_cfg_num_chgrp   (i_cfg_num_chgrp),
    .i_cfg_num_kngrp   (i_cfg_num_kngrp),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_weight_req      (o_weight_req),
    .i_weight_val      (i_weight_val),
    .i_engine_data_req (i_engine_data_req),
    .o_data_req        (o_data_req),
    .i_data_val        (i_data_val),
    .i_psum_val        (i_psum_val),
    .o_conf_ctrl       (o_conf_ctrl),
    .o_psum_first      (o_psum_first),
    .o_psum_last       (o_psum_last),
    .o_chgrp_idx       (o_chgrp_idx),
    .o_kngrp_idx       (o_kngrp_idx)
  );

  typedef enum int {EV_PASS, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cg;
    int       kg;
    bit       first;
    bit       last;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  cur;
  bit   cur_valid = 0;
  logic wreq_prev = 0;
  int   n_loadw = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic void push_ev(input ev_kind_e k, input int cg, input int kg, input int nc);
    ev_t e;
    e.kind = k; e.cg = cg; e.kg = kg; e.first = (cg == 0); e.last = (cg == nc - 1);
    exp_q.push_back(e);
  endfunction

  // Reference: a layer is the nested loop of passes, kernel group outer, then one done.
  function automatic void model_layer(input int lw, input int nc, input int nk);
    if (lw < NK || nc == 0 || nk == 0) begin
      push_ev(EV_ERR, 0, 0, 1);
    end else begin
      for (int kg = 0; kg < nk; kg++)
        for (int cg = 0; cg < nc; cg++)
          push_ev(EV_PASS, cg, kg, nc);
      push_ev(EV_DONE, 0, 0, 1);
    end
  endfunction

  function automatic void take_ev(input ev_kind_e k, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got unexpected event %0d, expected none", nm, int'(k));
    end else begin
      e = exp_q.pop_front();
      check(nm, 64'(int'(e.kind)), 64'(int'(k)));
      if (k == EV_PASS) begin
        cur = e;
        cur_valid = 1;
      end else begin
        cur_valid = 0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      wreq_prev = 0;
      cur_valid = 0;
    end else begin
      if (o_weight_req && !wreq_prev) begin
        n_loadw++;
        take_ev(EV_PASS, "pass_event");
      end
      if (cur_valid && o_busy && (o_weight_req || o_conf_ctrl[0]))
        check("pass_tags", {o_chgrp_idx, o_kngrp_idx, o_psum_first, o_psum_last},
              {CW'(cur.cg), CW'(cur.kg), cur.first, cur.last});
      if (o_done) take_ev(EV_DONE, "done_event");
      if (o_err)  take_ev(EV_ERR, "err_event");
      wreq_prev = o_weight_req;
    end
  end

  task automatic do_weights();
    int k = 0;
    int n = 0;
    while (!o_weight_req && k < 20) begin @(negedge clk); k++; end
    check("wreq_wait", o_weight_req, 1);
    while (n < WB) begin
      i_weight_val = ($urandom_range(0, 3) != 0);
      if (i_weight_val) n++;
      @(negedge clk);
    end
    i_weight_val = 0;
    check("wreq_drop", o_weight_req, 0);
    check("conf_stream", o_conf_ctrl, 1);
  endtask

  task automatic do_stream(input int lw, input int extra, input bit toggle, input bit mid_start);
    int acc = 0;
    int sent = 0;
    int it = 0;
    bit er = 0;
    bit v;
    while (sent < lw + extra) begin
      er = toggle ? !er : ($urandom_range(0, 1) == 1);
      v  = ($urandom_range(0, 3) != 0);
      i_engine_data_req = er;
      i_data_val        = v;
      i_start           = mid_start && (it == 0);
      #1 check("data_req", o_data_req, (er && acc < lw));
      if (v) begin
        sent++;
        if (acc < lw) acc++;
      end
      it++;
      @(negedge clk);
    end
    i_start = 0; i_data_val = 0; i_engine_data_req = 0;
  endtask

  task automatic do_drain(input int lw, input bit stall);
    int p = 0;
    int ne = stall ? 2 : lw - NK + 1;
    int k = 0;
    while (p < ne) begin
      i_psum_val = ($urandom_range(0, 2) != 0);
      if (i_psum_val) p++;
      @(negedge clk);
    end
    i_psum_val = 0;
    if (stall) begin
      while (!o_err && k < TO + 8) begin @(negedge clk); k++; end
      check("timeout_cycles", k, TO);
      check("timeout_conf", o_conf_ctrl, 0);
      check("timeout_busy", o_busy, 0);
      @(negedge clk);
      check("err_pulse", o_err, 0);
    end
  endtask

  task automatic run_layer(input int lw, input int nc, input int nk, input bit toggle,
                           input int extra, input bit mid_start, input bit stall);
    int l0 = n_loadw;
    bit bad = (lw < NK) || nc == 0 || nk == 0;
    if (stall) begin
      push_ev(EV_PASS, 0, 0, nc);
      push_ev(EV_ERR, 0, 0, 1);
    end else begin
      model_layer(lw, nc, nk);
    end
    i_cfg_line_width = CW'(lw);
    i_cfg_num_chgrp  = CW'(nc);
    i_cfg_num_kngrp  = CW'(nk);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    i_cfg_line_width = CW'($urandom_range(0, 20));
    i_cfg_num_chgrp  = CW'($urandom_range(0, 4));
    i_cfg_num_kngrp  = CW'($urandom_range(0, 4));
    if (bad) begin
      check("bad_err", o_err, 1);
      repeat (3) begin
        check("bad_busy", o_busy, 0);
        check("bad_wreq", o_weight_req, 0);
        @(negedge clk);
      end
      check("bad_err_pulse", o_err, 0);
    end else begin
      for (int p = 0; p < (stall ? 1 : nc * nk); p++) begin
        do_weights();
        do_stream(lw, extra, toggle, mid_start && p == 1);
        do_drain(lw, stall);
      end
      if (!stall) begin
        @(negedge clk);
        check("done_latency", o_done, 1);
        check("done_busy", o_busy, 1);
        @(negedge clk);
        check("post_done_busy", o_busy, 0);
        check("post_done_pulse", o_done, 0);
      end
      check("loadw_count", n_loadw - l0, stall ? 1 : nc * nk);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"}, o_busy, 0);
    check({nm, "_done"}, o_done, 0);
    check({nm, "_err"}, o_err, 0);
    check({nm, "_wreq"}, o_weight_req, 0);
    check({nm, "_dreq"}, o_data_req, 0);
    check({nm, "_conf"}, o_conf_ctrl, 0);
    check({nm, "_tags"}, {o_psum_first, o_psum_last, o_chgrp_idx, o_kngrp_idx}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 0;
    i_start = 0; i_weight_val = 0; i_engine_data_req = 0; i_data_val = 0; i_psum_val = 0;
    i_cfg_line_width = '0; i_cfg_num_chgrp = '0; i_cfg_num_kngrp = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1;
    @(negedge clk);

    run_layer(8, 1, 1, 0, 0, 0, 0);
    run_layer(5, 2, 2, 0, 0, 1, 0);
    run_layer(2, 1, 1, 0, 0, 0, 0);
    run_layer(8, 1, 0, 0, 0, 0, 0);
    run_layer(8, 1, 1, 1, 2, 0, 0);
    run_layer(8, 1, 1, 0, 0, 0, 1);
    run_layer(3, 3, 1, 0, 1, 0, 0);

    // Asynchronous reset in the middle of a line stream.
    model_layer(8, 2, 1);
    i_cfg_line_width = 8; i_cfg_num_chgrp = 2; i_cfg_num_kngrp = 1;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    do_weights();
    repeat (3) begin
      i_data_val = 1; i_engine_data_req = 1;
      @(negedge clk);
    end
    #2 rst = 0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    i_data_val = 0; i_engine_data_req = 0;
    #2 rst = 1;
    @(negedge clk);
    check_all_zero("after_reset");

    for (int r = 0; r < 4; r++)
      run_layer($urandom_range(3, 10), $urandom_range(1, 3), $urandom_range(1, 2),
                $urandom_range(0, 1) == 1, $urandom_range(0, 2), 0, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
